// File: rtl/ccw_output_channel_pkg.sv
// ccw_output_channel_pkg
// Shared constants for the counter-clockwise output channel and its arbiter:
// packet geometry, hop-field location, VC and requester indices. Also holds
// the hop rewrite applied to every packet as it is captured into a VC buffer.
package ccw_output_channel_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int HOP_MSB    = 55;
  localparam int HOP_LSB    = 48;
  localparam int HOP_WIDTH  = HOP_MSB - HOP_LSB + 1;

  // Virtual-channel indices
  localparam int VC_EVEN = 0;
  localparam int VC_ODD  = 1;

  // Requester indices inside one VC arbiter
  localparam int REQ_CCW = 0;
  localparam int REQ_PE  = 1;

  // Decrement the hop field. A hop count that is already zero stays at zero
  // instead of wrapping; every other bit passes through untouched.
  function automatic logic [DATA_WIDTH-1:0] hop_decrement(input logic [DATA_WIDTH-1:0] pkt);
    logic [DATA_WIDTH-1:0] result;
    logic [HOP_WIDTH-1:0]  hop;
    result = pkt;
    hop    = pkt[HOP_MSB:HOP_LSB];
    if (hop != '0) begin
      hop = hop - HOP_WIDTH'(1);
    end
    result[HOP_MSB:HOP_LSB] = hop;
    return result;
  endfunction

endpackage

// File: rtl/ccw_output_channel_if.sv
// ccw_output_channel_if
// Bundles everything the output channel exchanges with its neighbours:
//   polarity                         global VC phase (1: odd fills, even drains)
//   req_{ccw,pe}_{even,odd}          requests from ccw input / PE input stages
//   data_{ccw,pe}_{even,odd}         packets offered with those requests
//   grant_{ccw,pe}_{even,odd}        combinational grants back to the requesters
//   ccwro / ccwso / ccwdo            outgoing ccw link: ready in, send strobe and data out
// The slave modport is the channel itself; master is its environment.
interface ccw_output_channel_if;
  import ccw_output_channel_pkg::*;

  logic                  polarity;
  logic                  req_ccw_even;
  logic                  req_ccw_odd;
  logic                  req_pe_even;
  logic                  req_pe_odd;
  logic [DATA_WIDTH-1:0] data_ccw_even;
  logic [DATA_WIDTH-1:0] data_ccw_odd;
  logic [DATA_WIDTH-1:0] data_pe_even;
  logic [DATA_WIDTH-1:0] data_pe_odd;
  logic                  grant_ccw_even;
  logic                  grant_ccw_odd;
  logic                  grant_pe_even;
  logic                  grant_pe_odd;
  logic                  ccwro;
  logic                  ccwso;
  logic [DATA_WIDTH-1:0] ccwdo;

  modport master (
    output polarity,
    output req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd,
    output data_ccw_even, data_ccw_odd, data_pe_even, data_pe_odd,
    input  grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd,
    output ccwro,
    input  ccwso, ccwdo
  );

  modport slave (
    input  polarity,
    input  req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd,
    input  data_ccw_even, data_ccw_odd, data_pe_even, data_pe_odd,
    output grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd,
    input  ccwro,
    output ccwso, ccwdo
  );

endinterface

// File: rtl/ccw_output_channel_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk, rst   clock and asynchronous active-low reset
//   enable     arbitration allowed this cycle (fill side and buffer empty)
//   req[1:0]   requests, indexed by REQ_CCW / REQ_PE
//   grant[1:0] one-hot or zero combinational grant
// The pointer names the requester that wins when both request; it starts at
// REQ_CCW and moves to the other requester after every grant.
module rr_arb2
  import ccw_output_channel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic prio_reg;

  always_comb begin
    grant = 2'b00;
    // Gated with rst so no grant escapes while the channel is held in reset.
    if (rst && enable) begin
      if (req == 2'b11) begin
        grant[prio_reg] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_reg <= 1'(REQ_CCW);
    end else if (grant[REQ_CCW]) begin
      prio_reg <= 1'(REQ_PE);
    end else if (grant[REQ_PE]) begin
      prio_reg <= 1'(REQ_CCW);
    end
  end

endmodule

// File: rtl/ccw_output_channel.sv
// ccw_output_channel
// Counter-clockwise output stage. For each VC a round-robin arbiter picks
// between through-traffic (ccw input) and injection (PE input); the winner is
// captured, hop-decremented, into a one-entry VC buffer. The VC that is not
// filling this cycle may drain its buffer onto the ccw link when ccwro=1.
//   clk, rst   clock and asynchronous active-low reset
//   link       slave side of ccw_output_channel_if (requests, data, grants,
//              polarity, and the ccwro/ccwso/ccwdo link handshake)
module ccw_output_channel
  import ccw_output_channel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ccw_output_channel_if.slave  link
);

  // Per-VC views of the interface, indexed [vc][requester]
  logic [1:0]            req_vc   [2];
  logic [DATA_WIDTH-1:0] data_vc  [2][2];
  logic [1:0]            grant_vc [2];

  logic [1:0]            fill_side;
  logic [1:0]            full;
  logic [1:0]            drain_now;
  logic [DATA_WIDTH-1:0] pkt      [2];

  logic                  ccwso_reg;
  logic [DATA_WIDTH-1:0] ccwdo_reg;

  assign req_vc[VC_EVEN] = {link.req_pe_even, link.req_ccw_even};
  assign req_vc[VC_ODD]  = {link.req_pe_odd,  link.req_ccw_odd};

  assign data_vc[VC_EVEN][REQ_CCW] = link.data_ccw_even;
  assign data_vc[VC_EVEN][REQ_PE]  = link.data_pe_even;
  assign data_vc[VC_ODD][REQ_CCW]  = link.data_ccw_odd;
  assign data_vc[VC_ODD][REQ_PE]   = link.data_pe_odd;

  assign link.grant_ccw_even = grant_vc[VC_EVEN][REQ_CCW];
  assign link.grant_pe_even  = grant_vc[VC_EVEN][REQ_PE];
  assign link.grant_ccw_odd  = grant_vc[VC_ODD][REQ_CCW];
  assign link.grant_pe_odd   = grant_vc[VC_ODD][REQ_PE];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_vc
      logic                  full_reg;
      logic [DATA_WIDTH-1:0] pkt_reg;
      logic [DATA_WIDTH-1:0] captured;

      // polarity names the VC that fills: 1 -> odd, 0 -> even
      assign fill_side[gi] = (link.polarity == 1'(gi));

      // A VC can only drain while it is not the fill side, so a buffer is
      // never written and emptied on the same edge.
      assign drain_now[gi] = !fill_side[gi] && full_reg && link.ccwro;

      rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (fill_side[gi] && !full_reg),
        .req    (req_vc[gi]),
        .grant  (grant_vc[gi])
      );

      assign captured = grant_vc[gi][REQ_PE] ? data_vc[gi][REQ_PE] : data_vc[gi][REQ_CCW];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          full_reg <= 1'b0;
          pkt_reg  <= '0;
        end else if (|grant_vc[gi]) begin
          full_reg <= 1'b1;
          pkt_reg  <= hop_decrement(captured);
        end else if (drain_now[gi]) begin
          full_reg <= 1'b0;
        end
      end

      assign full[gi] = full_reg;
      assign pkt[gi]  = pkt_reg;
    end
  endgenerate

  // Link output: a one-cycle strobe per drained packet; data holds between
  // packets so downstream sees a stable bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccwso_reg <= 1'b0;
      ccwdo_reg <= '0;
    end else begin
      ccwso_reg <= |drain_now;
      if (drain_now[VC_ODD]) begin
        ccwdo_reg <= pkt[VC_ODD];
      end else if (drain_now[VC_EVEN]) begin
        ccwdo_reg <= pkt[VC_EVEN];
      end
    end
  end

  assign link.ccwso = ccwso_reg;
  assign link.ccwdo = ccwdo_reg;

endmodule

// File: tb/tb_ccw_output_channel.sv
// tb_ccw_output_channel
// Directed steps followed by randomized traffic, all checked against a
// packet-level reference model of the two VC buffers.
module tb_ccw_output_channel;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ccw_output_channel_if bus ();

  ccw_output_channel dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  int tests = 0;
  int fails = 0;

  // Data offered on each requester this cycle
  logic [63:0] d_ce, d_co, d_pe, d_po;

  // Reference model: VC index 0 = even, 1 = odd; requester 0 = ccw, 1 = pe
  logic        m_full [2];
  logic [63:0] m_buf  [2];
  int          m_ptr  [2];
  logic        m_so;
  logic [63:0] m_do;

  // Most recent observations of the DUT
  logic [3:0]  obs_g;   // {pe_odd, pe_even, ccw_odd, ccw_even}
  logic [3:0]  exp_g;
  logic        obs_so;
  logic [63:0] obs_do;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_hop(input logic [63:0] d);
    logic [63:0] r;
    int h;
    r = d;
    h = int'(d[55:48]);
    if (h > 0) h = h - 1;
    r[55:48] = 8'(h);
    return r;
  endfunction

  function automatic logic [63:0] pick(input int vc, input int who);
    if (vc == 0) return (who == 0) ? d_ce : d_pe;
    return (who == 0) ? d_co : d_po;
  endfunction

  task automatic m_reset();
    for (int v = 0; v < 2; v++) begin
      m_full[v] = 1'b0;
      m_buf[v]  = 64'h0;
      m_ptr[v]  = 0;
    end
    m_so = 1'b0;
    m_do = 64'h0;
  endtask

  // One clock cycle: drive inputs, check grants, let the edge pass, update
  // the model and check the link outputs.
  // req = {pe_odd, pe_even, ccw_odd, ccw_even}
  task automatic cycle(input logic pol, input logic [3:0] req, input logic ro);
    int f;
    int w;
    bus.polarity      = pol;
    bus.req_ccw_even  = req[0];
    bus.req_ccw_odd   = req[1];
    bus.req_pe_even   = req[2];
    bus.req_pe_odd    = req[3];
    bus.data_ccw_even = d_ce;
    bus.data_ccw_odd  = d_co;
    bus.data_pe_even  = d_pe;
    bus.data_pe_odd   = d_po;
    bus.ccwro         = ro;
    #1;
    f = pol ? 1 : 0;
    w = -1;
    exp_g = 4'b0000;
    if (rst && !m_full[f]) begin
      if (req[f] && req[2+f]) w = m_ptr[f];
      else if (req[f])        w = 0;
      else if (req[2+f])      w = 1;
    end
    if (w >= 0) exp_g[2*w+f] = 1'b1;
    obs_g = {bus.grant_pe_odd, bus.grant_pe_even, bus.grant_ccw_odd, bus.grant_ccw_even};
    check("grants", {60'h0, obs_g}, {60'h0, exp_g});
    @(posedge clk);
    if (!rst) begin
      m_reset();
    end else begin
      if (m_full[1-f] && ro) begin
        m_so = 1'b1;
        m_do = m_buf[1-f];
        m_full[1-f] = 1'b0;
      end else begin
        m_so = 1'b0;
      end
      if (w >= 0) begin
        m_buf[f]  = m_hop(pick(f, w));
        m_full[f] = 1'b1;
        m_ptr[f]  = 1 - w;
      end
    end
    #1;
    obs_so = bus.ccwso;
    obs_do = bus.ccwdo;
    check("ccwso", {63'h0, obs_so}, {63'h0, m_so});
    check("ccwdo", obs_do, m_do);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_pkt();
    logic [63:0] p;
    p = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) p[55:48] = 8'(($urandom_range(0, 1)));
    return p;
  endfunction

  initial begin
    logic pol;
    logic [3:0] rq;
    logic ro;

    m_reset();
    d_ce = 64'h1105_0000_0000_00C1;
    d_pe = 64'h2209_0000_0000_00D2;
    d_co = 64'h0A0A_0000_0000_0011;
    d_po = 64'h0B0B_0000_0000_0022;
    @(negedge clk);

    // Reset held with every request active
    cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 4'b1111, 1'b1);
    check("rst_grants", {60'h0, obs_g}, 64'h0);
    check("rst_ccwso", {63'h0, obs_so}, 64'h0);
    check("rst_ccwdo", obs_do, 64'h0);
    rst = 1'b1;

    // Contention on the even VC: ccw, pe, ccw
    cycle(1'b0, 4'b0101, 1'b1);
    check("cont_g1", {60'h0, obs_g}, 64'h1);
    cycle(1'b1, 4'b0101, 1'b1);
    check("cont_so1", {63'h0, obs_so}, 64'h1);
    check("cont_do1", obs_do, 64'h1104_0000_0000_00C1);
    cycle(1'b0, 4'b0101, 1'b1);
    check("cont_g2", {60'h0, obs_g}, 64'h4);
    cycle(1'b1, 4'b0101, 1'b1);
    check("cont_do2", obs_do, 64'h2208_0000_0000_00D2);
    cycle(1'b0, 4'b0101, 1'b1);
    check("cont_g3", {60'h0, obs_g}, 64'h1);
    cycle(1'b1, 4'b0000, 1'b1);
    check("cont_do3", obs_do, 64'h1104_0000_0000_00C1);

    // Single packet, hop 3 -> 2
    d_ce = 64'h0003_0000_0000_00AB;
    cycle(1'b0, 4'b0001, 1'b1);
    check("single_g", {60'h0, obs_g}, 64'h1);
    check("single_so_t", {63'h0, obs_so}, 64'h0);
    cycle(1'b1, 4'b0000, 1'b1);
    check("single_so", {63'h0, obs_so}, 64'h1);
    check("single_do", obs_do, 64'h0002_0000_0000_00AB);
    cycle(1'b0, 4'b0000, 1'b1);
    check("single_pulse", {63'h0, obs_so}, 64'h0);

    // Backpressure on the odd VC
    d_po = 64'h3307_0000_0000_0077;
    cycle(1'b1, 4'b1000, 1'b1);
    check("bp_fill", {60'h0, obs_g}, 64'h8);
    for (int i = 0; i < 5; i++) begin
      cycle((i % 2) == 1, 4'b1000, 1'b0);
      check("bp_so", {63'h0, obs_so}, 64'h0);
      check("bp_odd_g", {63'h0, (obs_g[3] | obs_g[1])}, 64'h0);
    end
    cycle(1'b1, 4'b1000, 1'b1);
    check("bp_full_g", {60'h0, obs_g}, 64'h0);
    cycle(1'b0, 4'b1000, 1'b1);
    check("bp_wrongphase", {63'h0, obs_g[3]}, 64'h0);
    check("bp_so_rel", {63'h0, obs_so}, 64'h1);
    check("bp_do_rel", obs_do, 64'h3306_0000_0000_0077);
    cycle(1'b1, 4'b1000, 1'b1);
    check("bp_resume", {60'h0, obs_g}, 64'h8);
    cycle(1'b0, 4'b0000, 1'b1);

    // Drain-side request ignored; hop floor at zero
    cycle(1'b0, 4'b1000, 1'b1);
    check("wrong_phase", {60'h0, obs_g}, 64'h0);
    d_ce = 64'h4400_0000_0000_0055;
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b1, 4'b0000, 1'b1);
    check("hop0_so", {63'h0, obs_so}, 64'h1);
    check("hop0_do", obs_do, 64'h4400_0000_0000_0055);

    // Asynchronous reset with the even buffer full
    d_ce = 64'h5509_0000_0000_0066;
    cycle(1'b0, 4'b0001, 1'b1);
    check("ar_fill", {60'h0, obs_g}, 64'h1);
    rst = 1'b0;
    #1;
    m_reset();
    check("ar_so_now", {63'h0, bus.ccwso}, 64'h0);
    check("ar_do_now", bus.ccwdo, 64'h0);
    check("ar_grant_now", {63'h0, bus.grant_ccw_even}, 64'h0);
    cycle(1'b1, 4'b0000, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle((i % 2) == 0, 4'b0000, 1'b1);
      check("ar_nosend", {63'h0, obs_so}, 64'h0);
    end
    cycle(1'b0, 4'b0101, 1'b1);
    check("ar_prio", {60'h0, obs_g}, 64'h1);

    // Randomized traffic
    pol = 1'b1;
    for (int i = 0; i < 400; i++) begin
      d_ce = rnd_pkt();
      d_co = rnd_pkt();
      d_pe = rnd_pkt();
      d_po = rnd_pkt();
      if ($urandom_range(0, 7) != 0) pol = ~pol;
      rq = 4'($urandom_range(0, 15));
      ro = ($urandom_range(0, 3) != 0);
      cycle(pol, rq, ro);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccw_output_channel.md
Name: ccw_output_channel

Overview:
- Counter-clockwise output stage of the router, directly downstream of the ccw input stage and the PE input stage.
- Per virtual channel (even/odd) it arbitrates round-robin between through-traffic from the ccw input and injections from the PE input.
- It grants one packet into a one-entry VC buffer, decrements the packet's hop field, and drives the outgoing ccw link with a send/ready handshake.
- Fill and drain of each VC alternate with the global polarity.

Parameters:
- DATA_WIDTH, 64, packet width.
- HOP_MSB, 55, hop-count field MSB.
- HOP_LSB, 48, hop-count field LSB.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- polarity  in  1  global VC phase; 1 = odd VC fills and even drains; 0 = even fills and odd drains.
- req_ccw_even  in  1  request from ccw input, even VC.
- req_ccw_odd  in  1  request from ccw input, odd VC.
- req_pe_even  in  1  request from PE input, even VC.
- req_pe_odd  in  1  request from PE input, odd VC.
- data_ccw_even  in  DATA_WIDTH  packet from ccw input, even VC.
- data_ccw_odd  in  DATA_WIDTH  packet from ccw input, odd VC.
- data_pe_even  in  DATA_WIDTH  packet from PE input, even VC.
- data_pe_odd  in  DATA_WIDTH  packet from PE input, odd VC.
- grant_ccw_even  out  1  grant to ccw input, even VC.
- grant_ccw_odd  out  1  grant to ccw input, odd VC.
- grant_pe_even  out  1  grant to PE input, even VC.
- grant_pe_odd  out  1  grant to PE input, odd VC.
- ccwro  in  1  downstream router ready.
- ccwso  out  1  send strobe on the ccw link.
- ccwdo  out  DATA_WIDTH  packet on the ccw link.

Behaviour:
- Reset (rst=0, asynchronous):
  - both VC buffers empty; ccwso=0; ccwdo=0.
  - both round-robin pointers point to ccw (ccw wins first).
  - all grants forced to 0 combinationally while rst=0.
- Fill side is the odd VC when polarity=1 and the even VC when polarity=0. Only the fill-side VC may issue a grant; requests on the drain-side VC are ignored (no grant, no state change).
- Grants are combinational:
  - at most one grant per cycle, only on the fill-side VC, only if that VC's buffer is empty.
  - if exactly one requester is active, that requester is granted.
  - if both are active, the requester named by that VC's priority pointer is granted.
- On the clk edge where a grant is high:
  - the granted data is captured into the VC buffer and the buffer is marked full.
  - the pointer flips to the other requester; pointers change only on a grant.
- Hop rewrite at capture: bits [HOP_MSB:HOP_LSB] are replaced by field−1. A field of 0 is held at 0 (no wrap). All other bits pass unchanged.
- Drain: at each edge, if the drain-side VC buffer is full and ccwro=1:
  - ccwso<=1 and ccwdo<=buffer.
  - the buffer is emptied.
- Otherwise ccwso<=0 and ccwdo holds its last value.
- ccwso is a single-cycle pulse per packet.
- Backpressure: while ccwro=0 a full buffer stays full. No grant is issued on that VC until it empties.
- Simultaneous fill and drain of the same VC is impossible by construction. Fill of one VC and drain of the other in the same cycle are both performed.
- Latency: grant in cycle t (VC is fill side) → capture at end of t → VC is drain side in t+1 (polarity toggles every cycle) → ccwso=1 visible in cycle t+2, provided ccwro=1 in t+1.
- If polarity is held constant, a full VC is not drained until polarity toggles.
- Reset asserted mid-operation:
  - any buffered packet is discarded.
  - ccwso/ccwdo drop to 0 immediately, not at the next edge.
  - after release, the first grant follows the reset priority.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, HOP_MSB, HOP_LSB.
  - VC index constants VC_EVEN=0 and VC_ODD=1.
  - requester constants REQ_CCW=0 and REQ_PE=1.
- One sub-module: rr_arb2, a two-requester round-robin arbiter with a registered priority pointer and the same asynchronous active-low reset. It is instantiated once per VC and qualified by fill-side and buffer-empty.

Test Plan:
- Reset:
  - drive rst=0 with requests active → all grants 0, ccwso=0, ccwdo=0.
  - release → first contended grant goes to ccw.
- Single packet:
  - polarity=0, req_ccw_even=1, data_ccw_even hop=0x03, payload 0xAB → grant_ccw_even=1 the same cycle.
  - two cycles later ccwso=1 for 1 cycle, ccwdo hop=0x02, other bits unchanged.
- Contention:
  - req_ccw_even and req_pe_even both held, polarity toggling, ccwro=1 → grants alternate ccw, pe, ccw on successive even-fill cycles.
  - packets appear on ccwdo in that order.
- Backpressure:
  - fill odd, then hold ccwro=0 for 5 cycles → ccwso=0 throughout, no grant_*_odd while full.
  - ccwro=1 → packet sent on the next odd-drain edge, then the odd grant resumes.
- Wrong phase and hop floor:
  - req_pe_odd=1 while polarity=0 → grant_pe_odd=0.
  - a packet with hop=0x00 → sent with hop=0x00.
- Async reset mid-flight:
  - even buffer full, rst pulsed low between edges → ccwso=0 and ccwdo=0 immediately.
  - no packet is sent after release.
